// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring integer divider for DIV / DIVU
//
// Ports:
//   clk           clock, all state changes on posedge
//   rst           synchronous reset, active-high
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until the result is consumed
//   annul_i       cancel the in-flight division (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result_o is valid
//
// Optional build macro: DIV_EARLY_TERM_EN
//   When defined, a request whose |dividend| < |divisor| skips the iteration
//   loop and presents {dividend, 0} one edge after acceptance.

module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE,
    S_BY_ZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;     // dividend bits shift out the top, quotient bits in the bottom
  logic [DATA_W-1:0]   dvs_q, dvs_d;     // |divisor|
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  // Operand magnitudes; the absolute value is only taken for signed requests
  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] dvd_abs, dvs_abs;

  assign dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign dvd_abs = dvd_neg ? -opdata1_i : opdata1_i;
  assign dvs_abs = dvs_neg ? -opdata2_i : opdata2_i;

  // One restoring step. Because rem_q < dvs_q, the shifted value is below
  // 2*dvs_q, so bit DATA_W of the (DATA_W+1)-bit difference is exactly the
  // borrow and the low DATA_W bits hold the new remainder when it is clear.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              borrow;

  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign borrow  = diff[DATA_W];

  // Sign correction applied on the final edge
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign quo_fix = neg_quot_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q  ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_o;
    ready_d    = ready_o;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          neg_quot_d = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          dvs_d      = dvs_abs;
          if (opdata2_i == '0) begin
            state_d = S_BY_ZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dvd_abs;
`ifdef DIV_EARLY_TERM_EN
            // Quotient is known to be zero: park the dividend magnitude in
            // the remainder and jump the counter to its final value so the
            // next edge takes the normal sign-correction/finish path.
            if (dvd_abs < dvs_abs) begin
              cnt_d = CNT_LAST;
              rem_d = dvd_abs;
              quo_d = '0;
            end
`endif
          end
        end
      end

      S_BY_ZERO: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_LAST) begin
          if (!borrow) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = S_END;
        end
      end

      S_END: begin
        if (!start_i || annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic with truncating division
  function automatic logic [63:0] model_res(logic [31:0] a, logic [31:0] b, logic s);
    int          sa, sb, q, r;
    logic [31:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv, qv};
  endfunction

  // Number of edges after the accepting edge until ready_o is seen high
  function automatic int model_lat(logic [31:0] a, logic [31:0] b, logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Presents a request and waits for ready_o; lat = -1 if it never arrives
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [63:0] res);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    res = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
    n_cmp++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic        ts [10];
    logic [63:0] te [10];
    int          lat;
    logic [63:0] res;
    ta = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd3, 32'd123, 32'hFFFF_FFF7, 32'hFFFF_FFF9, 32'hFFFF_FFF0};
    tb = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
           32'd10, 32'd0, 32'd4, 32'hFFFF_FFFE, 32'd3};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    te = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
           64'h00000000_80000000, 64'h00000000_FFFFFFFF, 64'h00000003_00000000,
           64'h00000000_00000000, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_00000003,
           64'h00000000_55555550};
    for (int i = 0; i < 10; i++) begin
      run_div(ta[i], tb[i], ts[i], lat, res);
      if (lat !== model_lat(ta[i], tb[i], ts[i])) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, model_lat(ta[i], tb[i], ts[i]));
      end
      n_cmp++;
      if (res !== te[i]) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, res, te[i]); end
      n_cmp++;
      repeat (2) @(posedge clk);
      #1;
      if (ready_o !== 1'b1 || result_o !== te[i]) begin
        n_err++; $display("FAIL dir%0d_hold: got ready %b result %h want 1 %h", i, ready_o, result_o, te[i]);
      end
      n_cmp++;
      start_i = 1'b0;
      @(posedge clk); #1;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        n_err++; $display("FAIL dir%0d_release: got ready %b result %h want 0 0", i, ready_o, result_o);
      end
      n_cmp++;
    end
  endtask

  // Cancel mid-iteration by annul (use_rst=0) or reset (use_rst=1)
  task automatic test_cancel(input logic use_rst);
    int          lat;
    logic [63:0] res;
    logic        seen;
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    if (seen !== 1'b0) begin n_err++; $display("FAIL cancel%0d_early_ready: got %b want 0", use_rst, seen); end
    n_cmp++;
    if (use_rst) rst = 1'b1;
    else annul_i = 1'b1;
    @(posedge clk); #1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_err++; $display("FAIL cancel%0d_state: got ready %b result %h want 0 0", use_rst, ready_o, result_o);
    end
    n_cmp++;
    rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    run_div(32'd50, 32'd5, 1'b0, lat, res);
    if (lat !== model_lat(32'd50, 32'd5, 1'b0)) begin
      n_err++; $display("FAIL cancel%0d_new_latency: got %0d want %0d", use_rst, lat, model_lat(32'd50, 32'd5, 1'b0));
    end
    n_cmp++;
    if (res !== 64'h00000000_0000000A) begin
      n_err++; $display("FAIL cancel%0d_new_result: got %h want %h", use_rst, res, 64'h00000000_0000000A);
    end
    n_cmp++;
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change();
    logic [31:0] a, b;
    logic [63:0] want;
    logic        seen;
    int          lat;
    a = 32'hFFF0_BDC0; b = 32'd37;
    want = model_res(a, b, 1'b1);
    opdata1_i = a; opdata2_i = b; signed_div_i = 1'b1;
    start_i = 1'b1; annul_i = 1'b0;
    lat = -1; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'b0;
      end
      if (ready_o) begin lat = k; seen = 1'b1; break; end
    end
    if (lat !== model_lat(a, b, 1'b1)) begin
      n_err++; $display("FAIL opchg_latency: got %0d want %0d", lat, model_lat(a, b, 1'b1));
    end
    n_cmp++;
    if (result_o !== want) begin n_err++; $display("FAIL opchg_result: got %h want %h", result_o, want); end
    n_cmp++;
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    int          lat;
    logic [63:0] res;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 20);
        4:       b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = $urandom_range(0, 50);
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      s = $urandom_range(0, 1);
      run_div(a, b, s, lat, res);
      if (lat !== model_lat(a, b, s)) begin
        n_err++; $display("FAIL rnd%0d_latency: a %h b %h s %b got %0d want %0d", i, a, b, s, lat, model_lat(a, b, s));
      end
      n_cmp++;
      if (res !== model_res(a, b, s)) begin
        n_err++; $display("FAIL rnd%0d_result: a %h b %h s %b got %h want %h", i, a, b, s, res, model_res(a, b, s));
      end
      n_cmp++;
      start_i = 1'b0;
      @(posedge clk); #1;
      if (ready_o !== 1'b0) begin n_err++; $display("FAIL rnd%0d_release: got %b want 0", i, ready_o); end
      n_cmp++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    test_reset();
    test_directed();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_operand_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
